// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake; ALU_SERIAL_SHIFT_EN selects a bit-serial shifter over the barrel shifter
module alu_mc #(
  parameter int XLEN     = 32,
  parameter int INC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SEQ  = 4'd8;
  localparam logic [3:0] ALU_SNE  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;
  localparam logic [3:0] ALU_SGE  = 4'd12;
  localparam logic [3:0] ALU_SGEU = 4'd13;
  localparam logic [3:0] ALU_INC  = 4'd14;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] y_n, res;
  logic [SW-1:0] amt;
  logic accept, eq, lt, ltu;
  assign amt       = b[SW-1:0];
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready && !flush;
  assign eq        = a == b;
  assign lt        = $signed(a) < $signed(b);
  assign ltu       = a < b;
`ifdef ALU_SERIAL_SHIFT_EN
  logic [XLEN-1:0] sh, sh_n, sh_step;
  logic [SW-1:0] cnt, cnt_n;
  logic [1:0] kind, kind_n;
  logic is_shift;
  assign is_shift = op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  assign sh_step  = kind == ALU_SLL[1:0] ? sh << 1 :
                    kind == ALU_SRL[1:0] ? sh >> 1 : {sh[XLEN-1], sh[XLEN-1:1]};
`endif
  // single-cycle result of every op; shifts here are the barrel path (also n=0 in serial mode)
  always_comb begin
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << amt;
      ALU_SRL:  res = a >> amt;
      ALU_SRA:  res = $signed(a) >>> amt;
      ALU_SEQ:  res = XLEN'(eq);
      ALU_SNE:  res = XLEN'(!eq);
      ALU_SLT:  res = XLEN'(lt);
      ALU_SLTU: res = XLEN'(ltu);
      ALU_SGE:  res = XLEN'(!lt);
      ALU_SGEU: res = XLEN'(!ltu);
      ALU_INC:  res = a + XLEN'(INC_STEP);
      default:  res = '0;
    endcase
  end
  // next state: flush wins, then drain of DONE, serial stepping, and a new acceptance overrides the drain
  always_comb begin
    state_n = state;
    y_n     = y;
`ifdef ALU_SERIAL_SHIFT_EN
    sh_n    = sh;
    cnt_n   = cnt;
    kind_n  = kind;
`endif
    if (flush) state_n = IDLE;
    else begin
      if (state == DONE && out_ready) state_n = IDLE;
`ifdef ALU_SERIAL_SHIFT_EN
      if (state == SHIFT) begin
        sh_n  = sh_step;
        cnt_n = cnt - SW'(1);
        if (cnt == SW'(1)) begin
          state_n = DONE;
          y_n     = sh_step;
        end
      end
      if (accept && is_shift && amt != '0) begin
        state_n = SHIFT;
        sh_n    = a;
        cnt_n   = amt;
        kind_n  = op[1:0];
      end else
`endif
      if (accept) begin
        state_n = DONE;
        y_n     = res;
      end
    end
  end
  // state and result registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      y     <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
      sh    <= '0;
      cnt   <= '0;
      kind  <= '0;
`endif
    end else begin
      state <= state_n;
      y     <= y_n;
`ifdef ALU_SERIAL_SHIFT_EN
      sh    <= sh_n;
      cnt   <= cnt_n;
      kind  <= kind_n;
`endif
    end
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits; legal values 32 and 64.
REQ-002 The block SHALL have parameter INC_STEP, default 4, constant added by ALU_INC.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  synchronous abort of the operation in flight.
REQ-006 The block SHALL have port in_valid  input  1  operation request valid.
REQ-007 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-008 The block SHALL have port op  input  4  operation code, CPU_pkg ALU_* encoding.
REQ-009 The block SHALL have ports a, b  input  XLEN  operands.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port y  output  XLEN  result.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-015 An operation SHALL be accepted on a rising edge with in_valid && in_ready; op, a, b are sampled only then.
REQ-016 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), giving back-to-back throughput of one non-shift op per cycle.
REQ-017 Non-shift ops SHALL register the result at acceptance and enter DONE; latency 1 cycle.
REQ-018 Results: ADD a+b, SUB a-b, AND, OR, XOR bitwise, INC a+INC_STEP, all modulo 2^XLEN; compare ops SEQ, SNE, SLT, SLTU, SGE, SGEU return zero-extended 1/0, signed compares in two's complement.
REQ-019 Shift amount SHALL be b[$clog2(XLEN)-1:0]; upper b bits ignored.
REQ-020 SRA SHALL replicate a[XLEN-1]; SRL and SLL SHALL fill with zeros.
REQ-021 Undefined op codes SHALL be accepted and produce y=0 with latency 1.
REQ-022 In DONE, y and out_valid SHALL hold stable until out_ready is high on an edge.
REQ-023 On out_valid && out_ready with no acceptance, state SHALL return to IDLE and out_valid deassert; with simultaneous acceptance, the new op proceeds as from IDLE.
REQ-024 flush SHALL have priority over all other inputs: next state IDLE, out_valid low, no acceptance that cycle.

Reset
REQ-025 reset SHALL immediately force state IDLE, out_valid=0, busy=0, y=0, shift counter=0, independent of clk.
REQ-026 in_ready SHALL be 1 while reset is asserted and after release.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result is delivered.

Configuration
REQ-028 Macro ALU_SERIAL_SHIFT_EN SHALL select the shifter implementation.
REQ-029 With ALU_SERIAL_SHIFT_EN defined: shift with amount n>0 SHALL load a and n at acceptance, enter SHIFT, shift one bit per cycle, decrement n, enter DONE on the edge where n reaches 0; latency n+1 cycles; n=0 goes directly to DONE with y=a, latency 1.
REQ-030 With ALU_SERIAL_SHIFT_EN undefined: shifts SHALL use a single-cycle barrel shifter with latency 1; SHIFT state is never entered.
REQ-031 Results SHALL be bit-identical in both configurations; only latency differs.

Verification
REQ-032 XLEN=32, out_ready=1: ADD a=0xFFFFFFFF b=1 -> y=0x00000000 one cycle after acceptance; SLT a=0xFFFFFFFF b=0 -> y=1; SLTU same operands -> y=0.
REQ-033 ALU_SERIAL_SHIFT_EN defined: SRA a=0x80000000 b=0x23 (n=3) -> busy 4 cycles, y=0xF0000000 with out_valid 4 cycles after acceptance; in_ready low during SHIFT.
REQ-034 Back-to-back: 8 consecutive INC ops a=0..7 with in_valid and out_ready held high -> one result per cycle, y=4..11 in order, in_ready never low.
REQ-035 Backpressure: XOR a=0xA5 b=0x0F with out_ready=0 for 5 cycles -> y=0xAA and out_valid held stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-036 flush during SHIFT of SLL n=10, then reset pulse during DONE of another op -> no result delivered either time; state IDLE, out_valid=0, y=0 after reset.
REQ-037 XLEN=64: SRL a=0x8000000000000000 b=63 -> y=1 in both configurations; op code 15 -> y=0, latency 1.
